// File: rtl/branch_pkg.sv
// Shared opcodes, condition codes, FSM state type and flag bit positions for the branch resolver.
// No logic here, so no latency.
// No flow control; these are constants and types only.
package branch_pkg;

    localparam logic [5:0] OP_B     = 6'b000101;
    localparam logic [7:0] OP_CBZ   = 8'b10110100;
    localparam logic [7:0] OP_BCOND = 8'b01010100;

    localparam logic [4:0] COND_EQ = 5'h00;
    localparam logic [4:0] COND_LT = 5'h0B;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } br_state_t;

    // Positions inside the {N,Z,C,V} flag vector
    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// The count updates one edge after inc is seen.
// No backpressure; inc is ignored once the counter is full.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (inc && !(&q)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Decodes B / CBZ / B.cond, resolves taken from the registered NZCV flags, and counts branches.
// Branch outputs are combinational (0 cycles); flags and counters update 1 edge later.
// No backpressure; outputs are gated to 0 while the post-reset warm-up runs.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int WARMUP_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic [3:0]       alu_flags,
    input  logic             set_flags,
    input  logic             cbz_zero,
    output logic [25:0]      imm26,
    output logic [18:0]      imm19,
    output logic             uncondBr,
    output logic             brTaken,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [3:0] WARM_INIT = 4'(WARMUP_CYCLES - 1);

    br_state_t  state, state_nxt;
    logic [3:0] warm_cnt;
    logic       run;
    logic       is_b, is_cbz, is_bcond, is_branch, taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WARMUP;
            warm_cnt <= WARM_INIT;
        end else begin
            state <= state_nxt;
            if (state == WARMUP && warm_cnt != 4'd0) begin
                warm_cnt <= warm_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == WARMUP && warm_cnt == 4'd0) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        run = (state == RUN);
    end

    assign imm26 = instr[25:0];
    assign imm19 = instr[23:5];

    always_comb begin
        is_b      = (instr[31:26] == OP_B);
        is_cbz    = (instr[31:24] == OP_CBZ);
        is_bcond  = (instr[31:24] == OP_BCOND);
        is_branch = is_b | is_cbz | is_bcond;
        taken     = 1'b0;
        if (is_b) begin
            taken = 1'b1;
        end else if (is_cbz) begin
            taken = cbz_zero;
        end else if (is_bcond) begin
            // Only EQ and LT are wired up; any other condition falls through as not taken
            if (instr[4:0] == COND_LT) begin
                taken = flags[N_IDX] ^ flags[V_IDX];
            end else if (instr[4:0] == COND_EQ) begin
                taken = flags[Z_IDX];
            end
        end
    end

    // AND with run so an undefined warm-up instr word resolves to 0, not X
    assign brTaken  = taken & run;
    assign uncondBr = is_b & run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else if (set_flags) begin
            flags <= alu_flags;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (is_branch & run),
        .q     (br_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (brTaken),
        .q     (taken_count)
    );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a reference model checked every negedge.
module tb_branch_resolver;

    localparam int WARM  = 2;
    localparam int CW    = 3;
    localparam int MAXC  = (1 << CW) - 1;

    localparam logic [31:0] I_B5   = 32'h14000005;
    localparam logic [31:0] I_BLT3 = 32'h5400006B;
    localparam logic [31:0] I_CBZ  = 32'hB4FFFFC1;
    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_SUBS = 32'hEB020020;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instr = I_B5;
    logic [3:0]    alu_flags = 4'b0000;
    logic          set_flags = 1'b0;
    logic          cbz_zero = 1'b0;
    logic [25:0]   imm26;
    logic [18:0]   imm19;
    logic          uncondBr;
    logic          brTaken;
    logic [3:0]    flags;
    logic [CW-1:0] br_count;
    logic [CW-1:0] taken_count;

    int checks = 0;
    int errors = 0;

    // Reference state
    int       m_edges = 0;
    logic [3:0] m_flags = 4'b0000;
    int       m_br = 0;
    int       m_tc = 0;

    branch_resolver #(.WARMUP_CYCLES(WARM), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .alu_flags   (alu_flags),
        .set_flags   (set_flags),
        .cbz_zero    (cbz_zero),
        .imm26       (imm26),
        .imm19       (imm19),
        .uncondBr    (uncondBr),
        .brTaken     (brTaken),
        .flags       (flags),
        .br_count    (br_count),
        .taken_count (taken_count)
    );

    always #5 clk = ~clk;

    function automatic bit m_is_branch(logic [31:0] i);
        return (i[31:26] === 6'b000101) || (i[31:24] === 8'hB4) || (i[31:24] === 8'h54);
    endfunction

    function automatic bit m_taken(logic [31:0] i, logic [3:0] f, logic cz);
        if (i[31:26] === 6'b000101) return 1'b1;
        if (i[31:24] === 8'hB4) return (cz === 1'b1);
        if (i[31:24] === 8'h54) begin
            if (i[4:0] === 5'h0B) return (f[3] != f[0]);
            if (i[4:0] === 5'h00) return (f[2] == 1'b1);
        end
        return 1'b0;
    endfunction

    function automatic bit m_run();
        return m_edges >= WARM;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_edges = 0;
            m_flags = 4'b0000;
            m_br    = 0;
            m_tc    = 0;
        end else begin
            if (m_run()) begin
                if (m_is_branch(instr) && m_br < MAXC) m_br++;
                if (m_taken(instr, m_flags, cbz_zero) && m_tc < MAXC) m_tc++;
            end
            if (set_flags) m_flags = alu_flags;
            if (m_edges < 100) m_edges++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("model_brTaken", 32'(brTaken), 32'(m_run() ? m_taken(instr, m_flags, cbz_zero) : 1'b0));
            check("model_uncondBr", 32'(uncondBr),
                  32'(m_run() ? (instr[31:26] === 6'b000101) : 1'b0));
            check("model_imm26", 32'(imm26), 32'(instr[25:0]));
            check("model_imm19", 32'(imm19), 32'(instr[23:5]));
            check("model_flags", 32'(flags), 32'(m_flags));
            check("model_br_count", 32'(br_count), 32'(m_br));
            check("model_taken_count", 32'(taken_count), 32'(m_tc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [3:0] af, input logic sf, input logic cz);
        instr     = i;
        alu_flags = af;
        set_flags = sf;
        cbz_zero  = cz;
        #1;
    endtask

    // Reset mid-cycle, check immediate effect, then run warm-up with X then zero instr words
    task automatic reset_pulse();
        reset = 1'b0;
        #1;
        check("rst_brTaken", 32'(brTaken), 32'd0);
        check("rst_br_count", 32'(br_count), 32'd0);
        check("rst_taken_count", 32'(taken_count), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive('x, 4'b0000, 1'b0, 1'b0);
        check("warm_x_brTaken", 32'(brTaken), 32'd0);
        tick();
        drive(32'h0, 4'b0000, 1'b0, 1'b0);
        check("warm_zero_brTaken", 32'(brTaken), 32'd0);
        tick();
    endtask

    initial begin
        // Reset and warm-up with B +5 held
        #3;
        check("reset_brTaken", 32'(brTaken), 32'd0);
        check("reset_uncondBr", 32'(uncondBr), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        check("reset_br_count", 32'(br_count), 32'd0);
        check("reset_imm26", 32'(imm26), 32'd5);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("warm0_brTaken", 32'(brTaken), 32'd0);
        tick();
        check("warm1_brTaken", 32'(brTaken), 32'd0);
        tick();
        check("run_brTaken", 32'(brTaken), 32'd1);
        check("run_uncondBr", 32'(uncondBr), 32'd1);
        check("run_imm26", 32'(imm26), 32'd5);
        check("run_br_count0", 32'(br_count), 32'd0);
        tick();
        check("run_br_count1", 32'(br_count), 32'd1);
        tick();
        check("run_br_count2", 32'(br_count), 32'd2);

        // SUBS sets N, then B.LT sees it
        drive(I_SUBS, 4'b1000, 1'b1, 1'b0);
        tick();
        drive(I_BLT3, 4'b0000, 1'b0, 1'b0);
        check("blt_flags", 32'(flags), 32'h8);
        check("blt_brTaken", 32'(brTaken), 32'd1);
        check("blt_uncondBr", 32'(uncondBr), 32'd0);
        check("blt_imm19", 32'(imm19), 32'd3);
        tick();

        // No forwarding: B.LT in the flag-setting cycle sees old flags
        drive(I_SUBS, 4'b0000, 1'b1, 1'b0);
        tick();
        drive(I_BLT3, 4'b1000, 1'b1, 1'b0);
        check("nofwd_brTaken", 32'(brTaken), 32'd0);
        tick();
        drive(I_BLT3, 4'b0000, 1'b0, 1'b0);
        check("nofwd_next_brTaken", 32'(brTaken), 32'd1);
        tick();

        // Fresh start, then CBZ with Rt nonzero then zero
        reset_pulse();
        drive(I_CBZ, 4'b0000, 1'b0, 1'b0);
        check("cbz0_brTaken", 32'(brTaken), 32'd0);
        check("cbz_imm19", 32'(imm19), 32'h7FFFE);
        tick();
        drive(I_CBZ, 4'b0000, 1'b0, 1'b1);
        check("cbz1_brTaken", 32'(brTaken), 32'd1);
        tick();
        check("cbz_taken_count", 32'(taken_count), 32'd1);
        check("cbz_br_count", 32'(br_count), 32'd2);

        // Non-branch ADD leaves counters alone; also load flags 0101
        drive(I_ADD, 4'b0101, 1'b1, 1'b0);
        check("add_brTaken", 32'(brTaken), 32'd0);
        check("add_uncondBr", 32'(uncondBr), 32'd0);
        tick();
        set_flags = 1'b0;
        check("add_br_count", 32'(br_count), 32'd2);
        check("add_taken_count", 32'(taken_count), 32'd1);
        check("add_flags", 32'(flags), 32'h5);

        // Saturation with B held for 10 RUN cycles
        drive(I_B5, 4'b0000, 1'b0, 1'b0);
        repeat (10) tick();
        check("sat_br_count", 32'(br_count), 32'd7);
        check("sat_taken_count", 32'(taken_count), 32'd7);

        // Mid-run reset clears everything before the next edge
        reset_pulse();
        drive(I_B5, 4'b0000, 1'b0, 1'b0);
        check("restart_brTaken", 32'(brTaken), 32'd1);
        tick();
        check("restart_br_count", 32'(br_count), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
